// File: rtl/due_bridge_pkg.sv
// Shared types and default widths for the Due bus bridge and the memory it fronts.
package due_bridge_pkg;

    localparam int ADDR_W = 22;
    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_RD_WAIT,
        ST_HOLD
    } state_t;

endpackage

// File: rtl/due_bus_bridge_strobe_sync.sv
// Multi-stage synchronizer for one asynchronous host strobe; resets to inactive.
module strobe_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic sync_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
        end
    end

    assign sync_o = sync_q[STAGES-1];

endmodule

// File: rtl/due_bus_bridge.sv
// Arduino Due static-memory bus to single-cycle memory request bridge.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | waiting for a synchronized strobe; both low -> bus_err
// ST_WRITE   | mem_w_en pulse is on the memory port
// ST_READ    | mem_r_en pulse is on the memory port
// ST_RD_WAIT | counting read latency; strobe drop aborts the read
// ST_HOLD    | bus_ready (and bus_oe for reads) until the strobe drops
module due_bus_bridge #(
    parameter int ADDR_W      = due_bridge_pkg::ADDR_W,
    parameter int DATA_W      = due_bridge_pkg::DATA_W,
    parameter int SYNC_STAGES = 2,
    parameter int RD_LATENCY  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bus_cs_n,
    input  logic              bus_rd_n,
    input  logic              bus_wr_n,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [DATA_W-1:0] bus_din,
    output logic [DATA_W-1:0] bus_dout,
    output logic              bus_oe,
    output logic              bus_ready,
    output logic              bus_err,
    output logic              mem_w_en,
    output logic              mem_r_en,
    output logic [ADDR_W-1:0] mem_w_addr,
    output logic [ADDR_W-1:0] mem_r_addr,
    output logic [DATA_W-1:0] mem_w_data,
    input  logic [DATA_W-1:0] mem_r_data
);
    import due_bridge_pkg::*;

    localparam int CNT_W = $clog2(RD_LATENCY + 1);

    logic rd_s;
    logic wr_s;

    strobe_sync #(.STAGES(SYNC_STAGES)) u_rd_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (!bus_cs_n && !bus_rd_n),
        .sync_o  (rd_s)
    );

    strobe_sync #(.STAGES(SYNC_STAGES)) u_wr_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (!bus_cs_n && !bus_wr_n),
        .sync_o  (wr_s)
    );

    state_t            state_q, state_d;
    logic              op_rd_q, op_rd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              w_en_q, w_en_d;
    logic              r_en_q, r_en_d;
    logic [ADDR_W-1:0] w_addr_q, w_addr_d;
    logic [ADDR_W-1:0] r_addr_q, r_addr_d;
    logic [DATA_W-1:0] w_data_q, w_data_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              oe_q, oe_d;
    logic              ready_q, ready_d;
    logic              err_q, err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_rd_q  <= 1'b0;
            cnt_q    <= '0;
            w_en_q   <= 1'b0;
            r_en_q   <= 1'b0;
            w_addr_q <= '0;
            r_addr_q <= '0;
            w_data_q <= '0;
            dout_q   <= '0;
            oe_q     <= 1'b0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_rd_q  <= op_rd_d;
            cnt_q    <= cnt_d;
            w_en_q   <= w_en_d;
            r_en_q   <= r_en_d;
            w_addr_q <= w_addr_d;
            r_addr_q <= r_addr_d;
            w_data_q <= w_data_d;
            dout_q   <= dout_d;
            oe_q     <= oe_d;
            ready_q  <= ready_d;
            err_q    <= err_d;
        end
    end

    // Enables and status are computed one state ahead so they come straight from flops.
    always_comb begin
        state_d  = state_q;
        op_rd_d  = op_rd_q;
        cnt_d    = cnt_q;
        w_en_d   = 1'b0;
        r_en_d   = 1'b0;
        w_addr_d = w_addr_q;
        r_addr_d = r_addr_q;
        w_data_d = w_data_q;
        dout_d   = dout_q;
        oe_d     = oe_q;
        ready_d  = ready_q;
        err_d    = err_q;

        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b0;
                oe_d    = 1'b0;
                if (rd_s && wr_s) begin
                    err_d = 1'b1;
                end else if (wr_s) begin
                    state_d  = ST_WRITE;
                    op_rd_d  = 1'b0;
                    w_en_d   = 1'b1;
                    w_addr_d = bus_addr;
                    w_data_d = bus_din;
                end else if (rd_s) begin
                    state_d  = ST_READ;
                    op_rd_d  = 1'b1;
                    r_en_d   = 1'b1;
                    r_addr_d = bus_addr;
                end
            end
            ST_WRITE: begin
                state_d = ST_HOLD;
                ready_d = 1'b1;
            end
            ST_READ: begin
                state_d = ST_RD_WAIT;
                cnt_d   = CNT_W'(RD_LATENCY);
            end
            ST_RD_WAIT: begin
                if (!rd_s) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_HOLD;
                    dout_d  = mem_r_data;
                    ready_d = 1'b1;
                    oe_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (op_rd_q ? !rd_s : !wr_s) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b0;
                    oe_d    = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus_dout   = dout_q;
    assign bus_oe     = oe_q;
    assign bus_ready  = ready_q;
    assign bus_err    = err_q;
    assign mem_w_en   = w_en_q;
    assign mem_r_en   = r_en_q;
    assign mem_w_addr = w_addr_q;
    assign mem_r_addr = r_addr_q;
    assign mem_w_data = w_data_q;

endmodule

// File: tb/tb_due_bus_bridge.sv
// Randomized scoreboard bench for due_bus_bridge with a behavioural memory attached.
module tb_due_bus_bridge;

    localparam int AW   = 22;
    localparam int DW   = 16;
    localparam int SYNC = 2;
    localparam int RDL  = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          bus_cs_n = 1'b1, bus_rd_n = 1'b1, bus_wr_n = 1'b1;
    logic [AW-1:0] bus_addr = '0;
    logic [DW-1:0] bus_din = '0;
    logic [DW-1:0] bus_dout;
    logic          bus_oe, bus_ready, bus_err;
    logic          mem_w_en, mem_r_en;
    logic [AW-1:0] mem_w_addr, mem_r_addr;
    logic [DW-1:0] mem_w_data;
    logic [DW-1:0] mem_r_data = '0;

    due_bus_bridge #(.ADDR_W(AW), .DATA_W(DW), .SYNC_STAGES(SYNC), .RD_LATENCY(RDL)) dut (
        .clk(clk), .rst_n(rst_n),
        .bus_cs_n(bus_cs_n), .bus_rd_n(bus_rd_n), .bus_wr_n(bus_wr_n),
        .bus_addr(bus_addr), .bus_din(bus_din), .bus_dout(bus_dout),
        .bus_oe(bus_oe), .bus_ready(bus_ready), .bus_err(bus_err),
        .mem_w_en(mem_w_en), .mem_r_en(mem_r_en),
        .mem_w_addr(mem_w_addr), .mem_r_addr(mem_r_addr),
        .mem_w_data(mem_w_data), .mem_r_data(mem_r_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;
    int rd_pulses = 0;

    // Memory environment: preloaded contents for 0..255, one-cycle registered read.
    logic [DW-1:0] init_mem [0:255];
    logic [DW-1:0] mem_arr [0:(1<<AW)-1];
    bit            mem_written [0:(1<<AW)-1];

    always @(posedge clk) begin
        if (mem_w_en) begin
            mem_arr[mem_w_addr]     <= mem_w_data;
            mem_written[mem_w_addr] <= 1'b1;
        end
        if (mem_r_en) begin
            if (mem_written[mem_r_addr])   mem_r_data <= mem_arr[mem_r_addr];
            else if (mem_r_addr < AW'(256)) mem_r_data <= init_mem[mem_r_addr[7:0]];
            else                            mem_r_data <= '0;
        end
    end

    // Reference model: what the host expects memory to contain.
    logic [DW-1:0] ref_mem [int];

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            cyc;
    } en_t;

    typedef struct {
        bit            rd;
        logic [DW-1:0] data;
        int            cyc;
    } rdy_t;

    en_t  exp_en_q[$];
    rdy_t exp_rdy_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Monitor: pops expectations whenever the DUT pulses an enable or raises ready.
    initial begin
        en_t  e;
        rdy_t r;
        logic rdy_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rdy_prev = 1'b0;
            end else begin
                if (mem_r_en) rd_pulses++;
                if (mem_w_en && mem_r_en) begin
                    flag("both_enables");
                end else if (mem_w_en || mem_r_en) begin
                    if (exp_en_q.size() == 0) begin
                        flag("unexpected_enable");
                    end else begin
                        e = exp_en_q.pop_front();
                        chk("en_kind", 32'(mem_w_en), 32'(e.wr));
                        chk("en_cycle", 32'(cyc), 32'(e.cyc));
                        if (e.wr) begin
                            chk("w_addr", 32'(mem_w_addr), 32'(e.addr));
                            chk("w_data", 32'(mem_w_data), 32'(e.data));
                        end else begin
                            chk("r_addr", 32'(mem_r_addr), 32'(e.addr));
                        end
                    end
                end
                if (bus_ready && !rdy_prev) begin
                    if (exp_rdy_q.size() == 0) begin
                        flag("unexpected_ready");
                    end else begin
                        r = exp_rdy_q.pop_front();
                        chk("ready_cycle", 32'(cyc), 32'(r.cyc));
                        chk("ready_oe", 32'(bus_oe), 32'(r.rd));
                        if (r.rd) chk("rd_data", 32'(bus_dout), 32'(r.data));
                    end
                end
                rdy_prev = bus_ready;
            end
        end
    end

    task automatic access(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d, input int extra);
        int   e0, ek, n;
        en_t  e;
        rdy_t r;
        @(negedge clk);
        bus_addr = a;
        bus_din  = d;
        bus_cs_n = 1'b0;
        if (wr) bus_wr_n = 1'b0;
        else    bus_rd_n = 1'b0;
        e0 = cyc + 1;
        if (wr) ref_mem[int'(a)] = d;
        e.wr = wr; e.addr = a; e.data = d; e.cyc = e0 + SYNC;
        exp_en_q.push_back(e);
        r.rd   = !wr;
        r.data = (!wr && ref_mem.exists(int'(a))) ? ref_mem[int'(a)] : '0;
        r.cyc  = e0 + SYNC + 1 + (wr ? 0 : RDL);
        exp_rdy_q.push_back(r);
        n = 0;
        while (!bus_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (!bus_ready) flag("ready_timeout");
        repeat (extra) @(negedge clk);
        bus_cs_n = 1'b1;
        bus_rd_n = 1'b1;
        bus_wr_n = 1'b1;
        ek = cyc + 1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus_ready && n < 10);
        chk("release_cycle", 32'(cyc), 32'(ek + SYNC));
        chk("release_oe", 32'(bus_oe), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        logic [AW-1:0] written[$];
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            p0, e0;
        en_t           e;

        for (int i = 0; i < 256; i++) begin
            d = DW'($urandom);
            init_mem[i] = d;
            ref_mem[i]  = d;
        end

        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(bus_ready), 32'd0);
        chk("rst_oe", 32'(bus_oe), 32'd0);
        chk("rst_err", 32'(bus_err), 32'd0);
        chk("rst_w_en", 32'(mem_w_en), 32'd0);
        chk("rst_r_en", 32'(mem_r_en), 32'd0);
        chk("rst_dout", 32'(bus_dout), 32'd0);
        chk("rst_w_addr", 32'(mem_w_addr), 32'd0);
        chk("rst_r_addr", 32'(mem_r_addr), 32'd0);
        chk("rst_w_data", 32'(mem_w_data), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        access(1'b1, AW'(22'h00000F), DW'(16'h00A5), 5);
        access(1'b0, AW'(22'h00000F), '0, 0);

        p0 = rd_pulses;
        for (int i = 0; i < 256; i++) access(1'b0, AW'(i), '0, int'($urandom_range(0, 2)));
        chk("rd_pulse_count", 32'(rd_pulses - p0), 32'd256);

        for (int i = 0; i < 30; i++) begin
            if (written.size() == 0 || $urandom_range(0, 1) == 0) begin
                a = AW'($urandom);
                d = DW'($urandom);
                written.push_back(a);
                access(1'b1, a, d, int'($urandom_range(0, 3)));
            end else begin
                access(1'b0, written[$urandom_range(0, written.size() - 1)], '0, int'($urandom_range(0, 3)));
            end
        end

        // Strobes with chip select inactive must be ignored.
        @(negedge clk);
        bus_addr = AW'($urandom);
        bus_rd_n = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("cs_high_rd_ready", 32'(bus_ready), 32'd0);
        end
        bus_rd_n = 1'b1;
        bus_wr_n = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("cs_high_wr_ready", 32'(bus_ready), 32'd0);
        end
        bus_wr_n = 1'b1;
        repeat (2) @(negedge clk);

        // Read released before the capture edge: one r_en, no ready.
        @(negedge clk);
        bus_addr = AW'(22'h000010);
        bus_cs_n = 1'b0;
        bus_rd_n = 1'b0;
        e0 = cyc + 1;
        e.wr = 1'b0; e.addr = AW'(22'h000010); e.data = '0; e.cyc = e0 + SYNC;
        exp_en_q.push_back(e);
        repeat (2) @(negedge clk);
        bus_cs_n = 1'b1;
        bus_rd_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            chk("abort_ready", 32'(bus_ready), 32'd0);
        end
        access(1'b1, AW'(22'h000123), DW'(16'h5A5A), 1);
        access(1'b0, AW'(22'h000123), '0, 1);

        // Both strobes low together.
        chk("err_before", 32'(bus_err), 32'd0);
        @(negedge clk);
        bus_cs_n = 1'b0;
        bus_rd_n = 1'b0;
        bus_wr_n = 1'b0;
        repeat (6) @(negedge clk);
        bus_cs_n = 1'b1;
        bus_rd_n = 1'b1;
        bus_wr_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("err_set", 32'(bus_err), 32'd1);
        chk("err_ready", 32'(bus_ready), 32'd0);
        access(1'b0, AW'(22'h00000F), '0, 0);
        chk("err_sticky", 32'(bus_err), 32'd1);

        // Reset in the middle of a read's latency wait.
        @(negedge clk);
        bus_addr = AW'(22'h000020);
        bus_cs_n = 1'b0;
        bus_rd_n = 1'b0;
        e0 = cyc + 1;
        e.wr = 1'b0; e.addr = AW'(22'h000020); e.data = '0; e.cyc = e0 + SYNC;
        exp_en_q.push_back(e);
        while (cyc < e0 + SYNC + 1) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_ready", 32'(bus_ready), 32'd0);
        chk("arst_oe", 32'(bus_oe), 32'd0);
        chk("arst_err", 32'(bus_err), 32'd0);
        chk("arst_r_en", 32'(mem_r_en), 32'd0);
        chk("arst_r_addr", 32'(mem_r_addr), 32'd0);
        chk("arst_w_addr", 32'(mem_w_addr), 32'd0);
        chk("arst_dout", 32'(bus_dout), 32'd0);
        bus_cs_n = 1'b1;
        bus_rd_n = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        access(1'b1, AW'(22'h3FFFFF), DW'(16'hFFFF), 2);
        access(1'b0, AW'(22'h3FFFFF), '0, 0);

        repeat (6) @(negedge clk);
        chk("en_queue_drained", 32'(exp_en_q.size()), 32'd0);
        chk("rdy_queue_drained", 32'(exp_rdy_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
